systolic_array_top: RTL and testbench

- Weight-stationary systolic matrix-multiply engine: computes R = A × W, with A and W both ARRAYHEIGHT×ARRAYWIDTH, and returns R one row per cycle.
- Contains three blocks:
  - weight buffer that preloads W into a PE grid;
  - input buffer that skews A rows into the grid;
  - output buffer that deskews column results back into rows.
- All phase enables come from an external controller or sequencer.

---
 rtl/systolic_array_pkg.sv | 11 +
 rtl/systolic_array_top_pe.sv | 57 +++++
 rtl/systolic_array_top.sv | 180 ++++++++++++++++++
 tb/tb_systolic_array_top.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_pkg.sv
// Shared defaults and lane geometry for the weight-stationary systolic matrix-multiply engine.
package systolic_array_pkg;
  localparam int DEF_DATASIZE            = 8;
  localparam int DEF_ARRAYWIDTH          = 4;
  localparam int DEF_ARRAYHEIGHT         = 4;
  localparam int DEF_OUTPUT_BUF_DATASIZE = 32;
  localparam int DEF_DSP_DELAY           = 1;

  localparam int DEF_ACT_BUS_W = DEF_DATASIZE * DEF_ARRAYWIDTH;
  localparam int DEF_RES_BUS_W = DEF_OUTPUT_BUF_DATASIZE * DEF_ARRAYWIDTH;
endpackage

// File: rtl/systolic_array_top_pe.sv
// Single processing element: stationary weight register, signed MAC and activation forwarding,
// both pipelined DSP_DELAY cycles deep.
module sa_pe
  import systolic_array_pkg::*;
#(
  parameter int DATASIZE            = DEF_DATASIZE,
  parameter int OUTPUT_BUF_DATASIZE = DEF_OUTPUT_BUF_DATASIZE,
  parameter int DSP_DELAY           = DEF_DSP_DELAY
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATASIZE-1:0]            i_act,
  input  logic [OUTPUT_BUF_DATASIZE-1:0] i_psum,
  input  logic                           i_weight_shift_en,
  input  logic [DATASIZE-1:0]            i_weight_in,
  output logic [DATASIZE-1:0]            o_weight,
  output logic [DATASIZE-1:0]            o_act,
  output logic [OUTPUT_BUF_DATASIZE-1:0] o_psum
);
  logic        [DATASIZE-1:0]            r_weight;
  logic        [DATASIZE-1:0]            r_act_pipe  [DSP_DELAY];
  logic        [OUTPUT_BUF_DATASIZE-1:0] r_psum_pipe [DSP_DELAY];
  logic signed [2*DATASIZE-1:0]          w_act_ext;
  logic signed [2*DATASIZE-1:0]          w_wgt_ext;
  logic signed [2*DATASIZE-1:0]          w_prod;
  logic signed [OUTPUT_BUF_DATASIZE-1:0] w_prod_ext;
  logic        [OUTPUT_BUF_DATASIZE-1:0] w_sum;

  // The full product fits in 2*DATASIZE bits; accumulation wraps at the psum width.
  assign w_act_ext  = (2*DATASIZE)'($signed(i_act));
  assign w_wgt_ext  = (2*DATASIZE)'($signed(r_weight));
  assign w_prod     = w_act_ext * w_wgt_ext;
  assign w_prod_ext = OUTPUT_BUF_DATASIZE'(w_prod);
  assign w_sum      = i_psum + w_prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_weight <= '0;
      for (int s = 0; s < DSP_DELAY; s++) begin
        r_act_pipe[s]  <= '0;
        r_psum_pipe[s] <= '0;
      end
    end else begin
      if (i_weight_shift_en) r_weight <= i_weight_in;
      r_act_pipe[0]  <= i_act;
      r_psum_pipe[0] <= w_sum;
      for (int s = 1; s < DSP_DELAY; s++) begin
        r_act_pipe[s]  <= r_act_pipe[s-1];
        r_psum_pipe[s] <= r_psum_pipe[s-1];
      end
    end
  end

  assign o_weight = r_weight;
  assign o_act    = r_act_pipe[DSP_DELAY-1];
  assign o_psum   = r_psum_pipe[DSP_DELAY-1];
endmodule

// File: rtl/systolic_array_top.sv
// Weight-stationary systolic engine computing R = A x W; all phase enables come from an external
// sequencer. Enables are plain per-cycle strobes: each high cycle performs exactly one action.
module systolic_array_top
  import systolic_array_pkg::*;
#(
  parameter int DATASIZE            = DEF_DATASIZE,
  parameter int ARRAYWIDTH          = DEF_ARRAYWIDTH,
  parameter int ARRAYHEIGHT         = DEF_ARRAYHEIGHT,
  parameter int OUTPUT_BUF_DATASIZE = DEF_OUTPUT_BUF_DATASIZE,
  parameter int DSP_DELAY           = DEF_DSP_DELAY
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      input_buffer_load_en,
  input  logic                                      input_buffer_out_en,
  input  logic                                      weight_buffer_load_en,
  input  logic                                      weight_buffer_out_en,
  input  logic                                      write_weight_en,
  input  logic                                      output_buffer_load_en,
  input  logic                                      output_buffer_out_en,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_act,
  input  logic [DATASIZE*ARRAYWIDTH-1:0]            in_weight,
  output logic [OUTPUT_BUF_DATASIZE*ARRAYWIDTH-1:0] out_res
);
  localparam int H     = ARRAYHEIGHT;
  localparam int W     = ARRAYWIDTH;
  localparam int D     = DSP_DELAY;
  localparam int DS    = DATASIZE;
  localparam int OW    = OUTPUT_BUF_DATASIZE;
  localparam int ROW_W = DS * W;
  localparam int PTR_W = (H > 1) ? $clog2(H) : 1;
  localparam int WIN_W = $clog2(D*(W-1) + H + 1) + 1;
  localparam logic [PTR_W-1:0] LAST_ROW = PTR_W'(H-1);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_ROW) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? LAST_ROW : p - 1'b1;
  endfunction

  logic [ROW_W-1:0] r_wbuf [H];
  logic [PTR_W-1:0] r_wwr_ptr;
  logic [PTR_W-1:0] r_wrd_ptr;
  logic             w_wpop;
  logic [ROW_W-1:0] w_wrow;

  // Rows leave in reverse load order so that after H shifts row k sits in PE row k.
  assign w_wpop = weight_buffer_out_en && write_weight_en;
  assign w_wrow = r_wbuf[r_wrd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < H; r++) r_wbuf[r] <= '0;
      r_wwr_ptr <= '0;
      r_wrd_ptr <= LAST_ROW;
    end else begin
      if (weight_buffer_load_en) begin
        r_wbuf[r_wwr_ptr] <= in_weight;
        r_wwr_ptr         <= ptr_inc(r_wwr_ptr);
      end
      if (w_wpop) r_wrd_ptr <= ptr_dec(r_wrd_ptr);
    end
  end

  logic [ROW_W-1:0] r_ibuf [H];
  logic [PTR_W-1:0] r_iwr_ptr;
  logic [PTR_W:0]   r_issue_cnt;
  logic             w_issue_valid;
  logic [ROW_W-1:0] w_issue_row;

  assign w_issue_valid = input_buffer_out_en && (r_issue_cnt < (PTR_W+1)'(H));
  assign w_issue_row   = w_issue_valid ? r_ibuf[r_issue_cnt[PTR_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < H; r++) r_ibuf[r] <= '0;
      r_iwr_ptr   <= '0;
      r_issue_cnt <= '0;
    end else begin
      if (input_buffer_load_en) begin
        r_ibuf[r_iwr_ptr] <= in_act;
        r_iwr_ptr         <= ptr_inc(r_iwr_ptr);
      end
      if (!input_buffer_out_en)  r_issue_cnt <= '0;
      else if (w_issue_valid)    r_issue_cnt <= r_issue_cnt + 1'b1;
    end
  end

  logic [DS-1:0] w_act  [H][W];
  logic [DS-1:0] w_wgt  [H][W];
  logic [OW-1:0] w_psum [H+1][W];
  logic [DS-1:0] w_unused_act [H];
  logic [DS-1:0] w_unused_wgt [W];

  for (genvar k = 0; k < H; k++) begin : g_skew
    if (k == 0) begin : g_direct
      assign w_act[0][0] = w_issue_row[0 +: DS];
    end else begin : g_delay
      logic [DS-1:0] r_dl [D*k];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < D*k; s++) r_dl[s] <= '0;
        end else begin
          r_dl[0] <= w_issue_row[k*DS +: DS];
          for (int s = 1; s < D*k; s++) r_dl[s] <= r_dl[s-1];
        end
      end
      assign w_act[k][0] = r_dl[D*k-1];
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_top
    assign w_psum[0][j] = '0;
    assign w_wgt[0][j]  = w_wrow[j*DS +: DS];
  end

  for (genvar k = 0; k < H; k++) begin : g_row
    for (genvar j = 0; j < W; j++) begin : g_col
      logic [DS-1:0] w_act_fwd;
      logic [DS-1:0] w_wgt_fwd;
      sa_pe #(
        .DATASIZE(DS), .OUTPUT_BUF_DATASIZE(OW), .DSP_DELAY(D)
      ) u_pe (
        .clk              (clk),
        .rst              (rst),
        .i_act            (w_act[k][j]),
        .i_psum           (w_psum[k][j]),
        .i_weight_shift_en(w_wpop),
        .i_weight_in      (w_wgt[k][j]),
        .o_weight         (w_wgt_fwd),
        .o_act            (w_act_fwd),
        .o_psum           (w_psum[k+1][j])
      );
      if (j < W-1) begin : g_act_fwd
        assign w_act[k][j+1] = w_act_fwd;
      end else begin : g_act_end
        assign w_unused_act[k] = w_act_fwd;
      end
      if (k < H-1) begin : g_wgt_fwd
        assign w_wgt[k+1][j] = w_wgt_fwd;
      end else begin : g_wgt_end
        assign w_unused_wgt[j] = w_wgt_fwd;
      end
    end
  end

  logic [OW-1:0]    r_obuf [H][W];
  logic [WIN_W-1:0] r_win_cnt;
  logic [PTR_W-1:0] r_ord_ptr;
  logic             w_cap_en  [W];
  logic [PTR_W-1:0] w_cap_row [W];

  // Column j results trail column 0 by D*j cycles; subtracting that offset deskews them into rows.
  for (genvar j = 0; j < W; j++) begin : g_cap
    localparam int OFS = D * j;
    assign w_cap_en[j]  = output_buffer_load_en && (int'(r_win_cnt) >= OFS) &&
                          (int'(r_win_cnt) < OFS + H);
    assign w_cap_row[j] = PTR_W'(int'(r_win_cnt) - OFS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < H; r++)
        for (int j = 0; j < W; j++) r_obuf[r][j] <= '0;
      r_win_cnt <= '0;
      r_ord_ptr <= '0;
    end else begin
      r_win_cnt <= output_buffer_load_en ? r_win_cnt + 1'b1 : '0;
      for (int j = 0; j < W; j++)
        if (w_cap_en[j]) r_obuf[w_cap_row[j]][j] <= w_psum[H][j];
      if (output_buffer_out_en) r_ord_ptr <= ptr_inc(r_ord_ptr);
    end
  end

  for (genvar j = 0; j < W; j++) begin : g_out
    assign out_res[j*OW +: OW] = output_buffer_out_en ? r_obuf[r_ord_ptr][j] : '0;
  end
endmodule

// File: tb/tb_systolic_array_top.sv
// Self-checking bench: a software matrix product fills the expected queue, emitted rows pop it.
module tb_systolic_array_top;
  localparam int DS = 8;
  localparam int N  = 4;
  localparam int OW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            input_buffer_load_en, input_buffer_out_en;
  logic            weight_buffer_load_en, weight_buffer_out_en, write_weight_en;
  logic            output_buffer_load_en, output_buffer_out_en;
  logic [DS*N-1:0] in_act, in_weight;
  logic [OW*N-1:0] out_res;

  logic signed [DS-1:0] mat_a [N][N];
  logic signed [DS-1:0] mat_w [N][N];
  logic [OW*N-1:0]      exp_q [$];
  int                   n_checks = 0;
  int                   n_errors = 0;

  systolic_array_top dut (
    .clk                  (clk),
    .rst                  (rst),
    .input_buffer_load_en (input_buffer_load_en),
    .input_buffer_out_en  (input_buffer_out_en),
    .weight_buffer_load_en(weight_buffer_load_en),
    .weight_buffer_out_en (weight_buffer_out_en),
    .write_weight_en      (write_weight_en),
    .output_buffer_load_en(output_buffer_load_en),
    .output_buffer_out_en (output_buffer_out_en),
    .in_act               (in_act),
    .in_weight            (in_weight),
    .out_res              (out_res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW*N-1:0] got, input logic [OW*N-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    input_buffer_load_en  = 1'b0;
    input_buffer_out_en   = 1'b0;
    weight_buffer_load_en = 1'b0;
    weight_buffer_out_en  = 1'b0;
    write_weight_en       = 1'b0;
    output_buffer_load_en = 1'b0;
    output_buffer_out_en  = 1'b0;
    in_act                = '0;
    in_weight             = '0;
  endtask

  function automatic logic [DS*N-1:0] pack_a(input int i);
    logic [DS*N-1:0] r;
    for (int k = 0; k < N; k++) r[k*DS +: DS] = mat_a[i][k];
    return r;
  endfunction

  function automatic logic [DS*N-1:0] pack_w(input int k);
    logic [DS*N-1:0] r;
    for (int j = 0; j < N; j++) r[j*DS +: DS] = mat_w[k][j];
    return r;
  endfunction

  task automatic push_expected();
    for (int i = 0; i < N; i++) begin
      logic [OW*N-1:0] row;
      for (int j = 0; j < N; j++) begin
        int acc;
        acc = 0;
        for (int k = 0; k < N; k++) acc += int'(mat_a[i][k]) * int'(mat_w[k][j]);
        row[j*OW +: OW] = acc;
      end
      exp_q.push_back(row);
    end
  endtask

  // Fixed schedule: W load 0-3, A load + weight write 4-7, issue 8-18, capture 12-18, emit 19-22.
  task automatic run_sched(input string name, input int abort_at);
    push_expected();
    for (int c = 0; c < 23; c++) begin
      if (c == abort_at) begin
        idle_inputs();
        rst = 1'b1;
        step();
        output_buffer_out_en = 1'b1;
        #1;
        check({name, "_in_reset"}, out_res, '0);
        step();
        rst = 1'b0;
        output_buffer_out_en = 1'b0;
        #1;
        check({name, "_after_reset"}, out_res, '0);
        step();
        exp_q.delete();
        return;
      end
      weight_buffer_load_en = (c < 4);
      in_weight             = (c < 4) ? pack_w(c) : '0;
      input_buffer_load_en  = (c >= 4 && c < 8);
      in_act                = (c >= 4 && c < 8) ? pack_a(c - 4) : '0;
      weight_buffer_out_en  = (c >= 4 && c < 8);
      write_weight_en       = (c >= 4 && c < 8);
      input_buffer_out_en   = (c >= 8 && c < 19);
      output_buffer_load_en = (c >= 12 && c < 19);
      output_buffer_out_en  = (c >= 19);
      #1;
      if (output_buffer_out_en) begin
        if (exp_q.size() == 0) check($sformatf("%s_row%0d_noexp", name, c - 19), out_res, 'x);
        else check($sformatf("%s_row%0d", name, c - 19), out_res, exp_q.pop_front());
      end else if (c == 15) begin
        check({name, "_capture_idle_out"}, out_res, '0);
      end
      step();
    end
    idle_inputs();
    #1;
    check({name, "_out_en_low"}, out_res, '0);
    step();
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        mat_a[i][k] = DS'($urandom_range(0, 255));
        mat_w[i][k] = DS'($urandom_range(0, 255));
      end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    output_buffer_out_en = 1'b1;
    #1;
    check("reset_out_en_high", out_res, '0);
    step();
    rst = 1'b0;
    output_buffer_out_en = 1'b0;
    #1;
    check("reset_released", out_res, '0);
    step();

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        mat_a[i][k] = DS'(4*i + k + 1);
        mat_w[i][k] = (i == k) ? 8'sd1 : 8'sd0;
      end
    run_sched("identity", -1);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        mat_a[i][k] = 8'sd1;
        mat_w[i][k] = 8'sd1;
      end
    run_sched("ones", -1);

    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        mat_a[i][k] = 8'h80;
        mat_w[i][k] = 8'h7F;
      end
    run_sched("signed", -1);

    for (int t = 0; t < 3; t++) begin
      fill_random();
      run_sched($sformatf("random%0d", t), -1);
    end

    fill_random();
    run_sched("abort", 14);
    run_sched("rerun", -1);
    fill_random();
    run_sched("after_rerun", -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
